// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: user command/stream, status and AXI4 channel bundle for axi_burst_master.
// The master modport is the burst master's view; the slave modport is the environment's view.
interface axi_burst_master_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 8
);
    localparam int STRB_W = DATA_W / 8;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              done;
    logic [1:0]        status_resp;
    logic              timeout;
    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              WDVALID;
    logic              WDREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic              RAVALID;
    logic              RAREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              RDVALID;
    logic              RDREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, wr_strb, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, status_resp, timeout,
        output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, WDVALID, WDATA, WSTRB, WLAST, BREADY,
        output RAVALID, ARADDR, ARLEN, ARSIZE, ARBURST, RDREADY,
        input  AWREADY, WDREADY, BVALID, BRESP, RAREADY, RDVALID, RDATA, RRESP, RLAST
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, wr_strb, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, status_resp, timeout,
        input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, WDVALID, WDATA, WSTRB, WLAST, BREADY,
        input  RAVALID, ARADDR, ARLEN, ARSIZE, ARBURST, RDREADY,
        output AWREADY, WDREADY, BVALID, BRESP, RAREADY, RDVALID, RDATA, RRESP, RLAST
    );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one user command into a full AXI4 INCR read or write burst.
// Optional stall watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_burst_master #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 128,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                clk,
    input logic                reset,
    axi_burst_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [1:0]        resp_acc;
    logic [1:0]        status_q;
    logic              cmd_rdy;
    logic              aw_v;
    logic              ar_v;
    logic              b_rdy;
    logic              done_q;
    logic              in_w;
    logic              in_r;
    logic              last;
    logic              w_hs;
    logic              r_hs;
    logic              hs;
    logic              accept;
    logic [1:0]        r_resp;
    logic [1:0]        r_stat;

    function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
        return a > b ? a : b;
    endfunction

    assign in_w   = state == WR_W;
    assign in_r   = state == RD_R;
    assign last   = cnt == len_q;
    assign accept = state == IDLE && bus.cmd_valid;
    assign w_hs   = in_w && bus.wr_valid && bus.WDREADY;
    assign r_hs   = in_r && bus.RDVALID && bus.rd_ready;
    assign hs     = (aw_v && bus.AWREADY) || w_hs || (b_rdy && bus.BVALID) || (ar_v && bus.RAREADY) || r_hs;
    assign r_resp = rmax(resp_acc, bus.RRESP);
    // A slave whose RLAST disagrees with the requested length is a protocol error: at least SLVERR.
    assign r_stat = (bus.RLAST != last) ? rmax(r_resp, 2'b10) : r_resp;

    assign bus.cmd_ready   = cmd_rdy;
    assign bus.done        = done_q;
    assign bus.status_resp = status_q;
    assign bus.AWVALID     = aw_v;
    assign bus.AWADDR      = addr_q;
    assign bus.AWLEN       = len_q;
    assign bus.AWSIZE      = 3'($clog2(DATA_W / 8));
    assign bus.AWBURST     = 2'b01;
    assign bus.WDVALID     = in_w && bus.wr_valid;
    assign bus.wr_ready    = in_w && bus.WDREADY;
    assign bus.WDATA       = bus.wr_data;
    assign bus.WSTRB       = bus.wr_strb;
    assign bus.WLAST       = in_w && last;
    assign bus.BREADY      = b_rdy;
    assign bus.RAVALID     = ar_v;
    assign bus.ARADDR      = addr_q;
    assign bus.ARLEN       = len_q;
    assign bus.ARSIZE      = 3'($clog2(DATA_W / 8));
    assign bus.ARBURST     = 2'b01;
    assign bus.RDREADY     = in_r && bus.rd_ready;
    assign bus.rd_valid    = in_r && bus.RDVALID;
    assign bus.rd_data     = bus.RDATA;
    assign bus.rd_last     = in_r && bus.RLAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt      <= '0;
            resp_acc <= 2'b00;
            status_q <= 2'b00;
            cmd_rdy  <= 1'b1;
            aw_v     <= 1'b0;
            ar_v     <= 1'b0;
            b_rdy    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    addr_q   <= bus.cmd_addr;
                    len_q    <= bus.cmd_len;
                    cnt      <= '0;
                    resp_acc <= 2'b00;
                    cmd_rdy  <= 1'b0;
                    aw_v     <= bus.cmd_rw;
                    ar_v     <= !bus.cmd_rw;
                    state    <= bus.cmd_rw ? WR_AW : RD_AR;
                end
                WR_AW: if (bus.AWREADY) begin
                    aw_v  <= 1'b0;
                    state <= WR_W;
                end
                WR_W: if (w_hs) begin
                    if (last) begin
                        b_rdy <= 1'b1;
                        state <= WR_B;
                    end else cnt <= cnt + 1'b1;
                end
                WR_B: if (bus.BVALID) begin
                    b_rdy    <= 1'b0;
                    status_q <= bus.BRESP;
                    done_q   <= 1'b1;
                    cmd_rdy  <= 1'b1;
                    state    <= IDLE;
                end
                RD_AR: if (bus.RAREADY) begin
                    ar_v  <= 1'b0;
                    state <= RD_R;
                end
                RD_R: if (r_hs) begin
                    resp_acc <= r_resp;
                    if (bus.RLAST || last) begin
                        status_q <= r_stat;
                        done_q   <= 1'b1;
                        cmd_rdy  <= 1'b1;
                        state    <= IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0] stall;
    logic          to_q;

    // The watchdog only flags; the FSM keeps waiting for the slave.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall <= '0;
            to_q  <= 1'b0;
        end else begin
            stall <= (state == IDLE || hs) ? '0 : (stall == SW'(TIMEOUT_CYC)) ? stall : stall + 1'b1;
            if (accept) to_q <= 1'b0;
            else if (state != IDLE && !hs && stall == SW'(TIMEOUT_CYC - 1)) to_q <= 1'b1;
        end
    end

    assign bus.timeout = to_q;
`else
    logic unused_stall;
    assign unused_stall = hs ^ accept;
    assign bus.timeout  = TIMEOUT_CYC < 0;
`endif
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed bursts against a scripted AXI slave, checked by queue-based monitors.
module tb_axi_burst_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int TO = 16;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [AW+LW-1:0] exp_aw[$];
    logic [AW+LW-1:0] exp_ar[$];
    logic [DW+4:0]    exp_w[$];
    logic [DW:0]      exp_r[$];
    logic [1:0]       exp_done[$];

    axi_burst_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus();

    axi_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [3:0] strb_of(input int i);
        return (i % 2 == 1) ? 4'h3 : 4'hF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) if (!reset && bus.AWVALID && bus.AWREADY) begin
        check("aw_expected", exp_aw.size() > 0, 1);
        if (exp_aw.size() > 0) check("aw_addr_len", {bus.AWADDR, bus.AWLEN}, exp_aw.pop_front());
        check("aw_size_burst", {bus.AWSIZE, bus.AWBURST}, {3'd2, 2'b01});
    end

    always @(negedge clk) if (!reset && bus.RAVALID && bus.RAREADY) begin
        check("ar_expected", exp_ar.size() > 0, 1);
        if (exp_ar.size() > 0) check("ar_addr_len", {bus.ARADDR, bus.ARLEN}, exp_ar.pop_front());
        check("ar_size_burst", {bus.ARSIZE, bus.ARBURST}, {3'd2, 2'b01});
    end

    always @(negedge clk) if (!reset && bus.WDVALID && bus.WDREADY) begin
        check("w_expected", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) check("w_data_strb_last", {bus.WDATA, bus.WSTRB, bus.WLAST}, exp_w.pop_front());
        check("w_no_bready_awvalid", {bus.BREADY, bus.AWVALID}, 0);
    end

    always @(negedge clk) if (!reset && bus.rd_valid && bus.rd_ready) begin
        check("r_expected", exp_r.size() > 0, 1);
        if (exp_r.size() > 0) check("r_data_last", {bus.rd_data, bus.rd_last}, exp_r.pop_front());
    end

    always @(negedge clk) if (!reset && bus.done) begin
        check("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) check("status_resp", bus.status_resp, exp_done.pop_front());
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- user side ----------------
    task automatic issue_cmd(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            tick();
            k++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        if (rw) exp_aw.push_back({a, l});
        else exp_ar.push_back({a, l});
        tick();
        bus.cmd_valid = 1'b0;
        check("addr_valid_latency", rw ? bus.AWVALID : bus.RAVALID, 1);
        check("cmd_ready_busy", bus.cmd_ready, 0);
        check("timeout_clear", bus.timeout, 0);
    endtask

    task automatic user_wr(input logic [AW-1:0] a, input int len, input logic [DW-1:0] base,
                           input logic [DW-1:0] inc, input bit gaps);
        int  i;
        int  k;
        bit  hs;
        logic [DW-1:0] d;
        issue_cmd(1'b1, a, LW'(len));
        for (int j = 0; j <= len; j++) begin
            d = base + DW'(j) * inc;
            exp_w.push_back({d, strb_of(j), j == len});
        end
        i = 0;
        k = 0;
        while (i <= len && k < 500) begin
            bus.wr_valid = !gaps || (k % 3 != 1);
            bus.wr_data  = base + DW'(i) * inc;
            bus.wr_strb  = strb_of(i);
            @(negedge clk);
            hs = bus.wr_valid && bus.wr_ready;
            tick();
            if (hs) i++;
            k++;
        end
        bus.wr_valid = 1'b0;
        check("wr_beats", i, len + 1);
        k = 0;
        while (!bus.done && k < 200) begin
            tick();
            k++;
        end
        check("wr_done_wait", bus.done, 1);
    endtask

    task automatic user_rd(input logic [AW-1:0] a, input int len, input bit tog);
        int k;
        issue_cmd(1'b0, a, LW'(len));
        k = 0;
        while (!bus.done && k < 500) begin
            bus.rd_ready = !tog || (k % 2 == 0);
            tick();
            k++;
        end
        bus.rd_ready = 1'b0;
        check("rd_done_wait", bus.done, 1);
    endtask

    // ---------------- slave side ----------------
    task automatic slave_wr(input int aw_dly, input bit tog, input int b_dly, input logic [1:0] bresp);
        int k;
        k = 0;
        while (!bus.AWVALID && k < 50) begin
            tick();
            k++;
        end
        check("awvalid_wait", bus.AWVALID, 1);
        repeat (aw_dly) tick();
        bus.AWREADY = 1'b1;
        tick();
        bus.AWREADY = 1'b0;
        k = 0;
        while (!bus.BREADY && k < 500) begin
            bus.WDREADY = !tog || (k % 2 == 0);
            tick();
            k++;
        end
        bus.WDREADY = 1'b0;
        check("bready_wait", bus.BREADY, 1);
        repeat (b_dly) tick();
        bus.BVALID = 1'b1;
        bus.BRESP  = bresp;
        tick();
        bus.BVALID = 1'b0;
        bus.BRESP  = 2'b00;
    endtask

    task automatic slave_rd(input int n, input int rlast_at, input int err_at, input logic [1:0] err,
                            input logic [DW-1:0] base);
        int k;
        bit hs;
        k = 0;
        while (!bus.RAVALID && k < 50) begin
            tick();
            k++;
        end
        check("ravalid_wait", bus.RAVALID, 1);
        bus.RAREADY = 1'b1;
        tick();
        bus.RAREADY = 1'b0;
        for (int j = 0; j < n; j++) begin
            bus.RDVALID = 1'b1;
            bus.RDATA   = base + DW'(j);
            bus.RRESP   = (j == err_at) ? err : 2'b00;
            bus.RLAST   = j == rlast_at;
            k  = 0;
            hs = 1'b0;
            while (!hs && k < 100) begin
                @(negedge clk);
                hs = bus.RDVALID && bus.RDREADY;
                tick();
                k++;
            end
            check("r_beat_wait", hs, 1);
        end
        bus.RDVALID = 1'b0;
        bus.RLAST   = 1'b0;
        bus.RRESP   = 2'b00;
    endtask

    task automatic to_check();
        int k;
        k = 0;
        while (!bus.BREADY && k < 200) begin
            tick();
            k++;
        end
        repeat (10) tick();
        check("timeout_early", bus.timeout, 0);
        repeat (8) tick();
`ifdef AXI_MASTER_TIMEOUT_EN
        check("timeout_set", bus.timeout, 1);
`else
        check("timeout_off", bus.timeout, 0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit hs;
        int k;
        reset = 1'b1;
        {bus.cmd_valid, bus.cmd_rw, bus.cmd_addr, bus.cmd_len} = '0;
        {bus.wr_valid, bus.wr_data, bus.wr_strb, bus.rd_ready} = '0;
        {bus.AWREADY, bus.WDREADY, bus.BVALID, bus.BRESP, bus.RAREADY} = '0;
        {bus.RDVALID, bus.RDATA, bus.RRESP, bus.RLAST} = '0;
        repeat (2) tick();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_valid_ready", {bus.AWVALID, bus.WDVALID, bus.BREADY, bus.RAVALID, bus.RDREADY, bus.done}, 0);
        check("rst_status_timeout", {bus.status_resp, bus.timeout}, 0);
        check("rst_addr_len", {bus.AWADDR, bus.AWLEN}, 0);
        reset = 1'b0;
        tick();
        check("idle_cmd_ready", bus.cmd_ready, 1);

        // write len=0, AWREADY 3 cycles late
        exp_done.push_back(2'b00);
        fork
            user_wr(32'h1000, 0, 32'hA5A5A5A5, 32'h0, 1'b0);
            slave_wr(3, 1'b0, 0, 2'b00);
        join

        // write len=3 with WDREADY toggling and wr_valid gaps
        exp_done.push_back(2'b01);
        fork
            user_wr(32'h2040, 3, 32'h11223344, 32'h01010101, 1'b1);
            slave_wr(0, 1'b1, 2, 2'b01);
        join

        // read len=7, rd_ready toggling, SLVERR on beat 3
        for (int j = 0; j < 8; j++) exp_r.push_back({32'hC0DE0000 + DW'(j), j == 7});
        exp_done.push_back(2'b10);
        fork
            user_rd(32'h3000, 7, 1'b1);
            slave_rd(8, 7, 2, 2'b10, 32'hC0DE0000);
        join

        // read len=3, slave ends early with RLAST on beat 2
        for (int j = 0; j < 2; j++) exp_r.push_back({32'hBEEF0000 + DW'(j), j == 1});
        exp_done.push_back(2'b10);
        fork
            user_rd(32'h4000, 3, 1'b0);
            slave_rd(2, 1, -1, 2'b00, 32'hBEEF0000);
        join

        // write with BVALID withheld 20 cycles
        exp_done.push_back(2'b10);
        fork
            user_wr(32'h5000, 0, 32'h5A5A5A5A, 32'h0, 1'b0);
            slave_wr(0, 1'b0, 20, 2'b10);
            to_check();
        join

        // read len=0, EXOKAY; accept also clears a sticky timeout
        exp_r.push_back({32'h00000077, 1'b1});
        exp_done.push_back(2'b01);
        fork
            user_rd(32'h6000, 0, 1'b0);
            slave_rd(1, 0, 0, 2'b01, 32'h00000077);
        join

        // reset after first write beat of len=3
        bus.AWREADY  = 1'b1;
        bus.WDREADY  = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hDEAD0000;
        bus.wr_strb  = 4'hF;
        issue_cmd(1'b1, 32'h7000, 8'd3);
        exp_w.push_back({32'hDEAD0000, 4'hF, 1'b0});
        hs = 1'b0;
        k  = 0;
        while (!hs && k < 50) begin
            @(negedge clk);
            hs = bus.WDVALID && bus.WDREADY;
            k++;
        end
        check("rst_beat_wait", hs, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async_valid_ready",
              {bus.AWVALID, bus.WDVALID, bus.wr_ready, bus.BREADY, bus.RAVALID, bus.RDREADY, bus.rd_valid}, 0);
        check("rst_async_cmd_ready", bus.cmd_ready, 1);
        repeat (2) tick();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("post_rst_no_wdvalid", bus.WDVALID, 0);
        end
        check("post_rst_cmd_ready", bus.cmd_ready, 1);
        bus.AWREADY  = 1'b0;
        bus.WDREADY  = 1'b0;
        bus.wr_valid = 1'b0;
        tick();

        check("aw_left", exp_aw.size(), 0);
        check("ar_left", exp_ar.size(), 0);
        check("w_left", exp_w.size(), 0);
        check("r_left", exp_r.size(), 0);
        check("done_left", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
